fp32_to_bf16_narrow: RTL
========================

// Module: fp32_to_bf16_narrow
// PURPOSE
//  Narrows fp32 products from the bf16 multiplier (or any fp32 source) back to bf16
//  for write-back into operand buffers. Two-stage pipelined rounding unit with
//  valid/ready handshakes on both sides. Emits per-result inexact/overflow flags
//  and keeps saturating event counters. Sits between the fp32 PE/accumulator
//  output and the bf16 result FIFO.
// PARAMETERS
//  ROUND_MODE  0   0 = round-to-nearest-even (RNE); 1 = truncate toward zero
//  CNT_W       16  width of each saturating status counter
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst          in   1      synchronous, active-high reset
//  in_valid     in   1      in_data holds a valid fp32 word
//  in_ready     out  1      unit accepts in_data this cycle
//  in_data      in   32     fp32 word {sign, exp[7:0], mant[22:0]}
//  out_valid    out  1      out_data is valid
//  out_ready    in   1      consumer accepts out_data this cycle
//  out_data     out  16     bf16 word {sign, exp[7:0], mant[6:0]}
//  out_inexact  out  1      discarded bits in_data[15:0] were nonzero (finite input)
//  out_overflow out  1      finite input rounded to infinity
//  stat_clr     in   1      synchronous clear of both counters
//  inexact_cnt  out  CNT_W  saturating count of delivered inexact results
//  ovf_cnt      out  CNT_W  saturating count of delivered overflow results
// BEHAVIOUR
//  Reset: all outputs are 0, including out_valid, flags, counters and out_data.
//   Both pipeline valids are cleared. Reset mid-stream drops in-flight data.
//  Handshake:
//   - Input transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
//   - out_data and flags hold stable while out_valid & !out_ready.
//  Pipeline: S1 captures the input and precomputes classify/rounding. S2 holds the result.
//   - s2_adv = !s2_valid | out_ready.
//   - in_ready = !s1_valid | s2_adv. This is a combinational path from out_ready.
//   - Latency is 2 cycles from input transfer to out_valid when there is no stall.
//   - Throughput is 1 per cycle, and ordering is strictly preserved.
//  Classify input x:
//   - NaN (exp=FF, mant!=0) -> 16'h7FFF (canonical, sign cleared); flags 0.
//   - Inf (exp=FF, mant=0)  -> {x[31], 8'hFF, 7'h0}; flags 0.
//   - Finite (incl. zero and subnormal) -> rounded as below.
//  Rounding (finite):
//   - lsb = x[16], guard = x[15], sticky = |x[14:0].
//   - RNE: inc = guard & (sticky | lsb). Truncate: inc = 0.
//   - out_data = x[31:16] + inc (16-bit add). Mantissa carry propagates into the exponent.
//   - Subnormal max rounds up to min normal.
//   - Sign is unchanged; -0 stays 16'h8000.
//   - out_inexact = |x[15:0].
//   - out_overflow = (x[30:23] != FF) & (result[14:7] == FF).
//  Counters:
//   - Each counter increments by 1 on an output transfer whose flag is set.
//   - Counters saturate at all-ones.
//   - stat_clr has priority over an increment in the same cycle.
//   - rst clears both counters.
// TESTING
//  1. in 32'h3F800000 with out_ready=1 -> out_valid exactly 2 cycles later, out 16'h3F80, inexact=0.
//  2. Rounding: 32'h3F808000 -> 16'h3F80 (tie, even); 32'h3F818000 -> 16'h3F82; 32'h3F808001 -> 16'h3F81.
//     Inexact=1 on all three. With ROUND_MODE=1 all three give 16'h3F80/16'h3F81 truncated.
//  3. Specials:
//     - 32'h7F7FFFFF -> 16'h7F80, overflow=1, ovf_cnt+1.
//     - 32'hFFC00001 -> 16'h7FFF.
//     - 32'hFF800000 -> 16'hFF80.
//     - 32'h00018000 -> 16'h0002.
//     - 32'h007F8000 -> 16'h0080.
//  4. Backpressure: stream 6 words (1..6 as 32'h3F80_0000+k<<16) with out_ready=0 for 5 cycles.
//     - in_ready drops after 2 accepted.
//     - After release, all 6 emerge in order, none lost or duplicated.
//     - out_data stays stable while stalled.
//  5. Reset mid-operation: assert rst with both stages valid.
//     - Next cycle out_valid=0 and in_ready=1.
//     - Counters read 0.
//     - The next input emerges normally after 2 cycles.
//  6. Counters: drive 2^CNT_W+3 inexact inputs -> inexact_cnt saturates at all-ones.
//     - stat_clr coincident with a transfer gives 0.
//  7. Random: 1e6 random fp32 inputs with random stalls.
//     - Compare against the reference model: RNE narrowing per above, plus a NaN canonicalisation rule.

Source files
------------

// File: rtl/fp32_to_bf16_narrow.sv
// fp32_to_bf16_narrow
// Two-stage fp32 -> bf16 narrowing unit. Stage 1 captures the fp32 word and
// pre-decides classification and the rounding increment; stage 2 holds the
// finished bf16 result and its flags until the consumer takes it. Inexact and
// overflow events on delivered results feed two saturating counters.
module fp32_to_bf16_narrow #(
    parameter int ROUND_MODE = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_inexact,
    output logic             out_overflow,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] inexact_cnt,
    output logic [CNT_W-1:0] ovf_cnt
);

    logic        s1_valid;
    logic [15:0] s1_upper;
    logic        s1_nan;
    logic        s1_inf;
    logic        s1_inc;
    logic        s1_inexact;

    logic        s2_valid;
    logic        s2_adv;
    logic        out_fire;

    logic        exp_all_ones;
    logic        pre_nan;
    logic        pre_inf;
    logic        pre_inc;
    logic        pre_inexact;

    logic [15:0] rounded;
    logic [15:0] rnd_data;
    logic        rnd_inexact;
    logic        rnd_overflow;

    // Stage 2 may advance when empty or when its result is being taken;
    // stage 1 may accept when empty or when it can move into stage 2.
    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign out_valid = s2_valid;
    assign out_fire  = s2_valid && out_ready;

    // Classify the incoming word and decide the rounding increment up front
    always_comb begin
        exp_all_ones = &in_data[30:23];
        pre_nan      = exp_all_ones && (|in_data[22:0]);
        pre_inf      = exp_all_ones && !(|in_data[22:0]);
        pre_inexact  = |in_data[15:0];
        pre_inc      = 1'b0;
        if (ROUND_MODE == 0) begin
            pre_inc = in_data[15] && ((|in_data[14:0]) || in_data[16]);
        end
    end

    // Stage 1 register: keep only the upper half plus the precomputed decisions
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_upper   <= 16'h0000;
            s1_nan     <= 1'b0;
            s1_inf     <= 1'b0;
            s1_inc     <= 1'b0;
            s1_inexact <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_upper   <= in_data[31:16];
                s1_nan     <= pre_nan;
                s1_inf     <= pre_inf;
                s1_inc     <= pre_inc;
                s1_inexact <= pre_inexact;
            end
        end
    end

    // Apply the increment (carry may ripple into the exponent) and resolve specials
    always_comb begin
        rounded      = s1_upper + {15'd0, s1_inc};
        rnd_data     = rounded;
        rnd_inexact  = s1_inexact;
        rnd_overflow = &rounded[14:7];
        if (s1_nan) begin
            rnd_data     = 16'h7FFF;
            rnd_inexact  = 1'b0;
            rnd_overflow = 1'b0;
        end else if (s1_inf) begin
            rnd_data     = {s1_upper[15], 8'hFF, 7'h00};
            rnd_inexact  = 1'b0;
            rnd_overflow = 1'b0;
        end
    end

    // Stage 2 register: result and flags hold steady while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid     <= 1'b0;
            out_data     <= 16'h0000;
            out_inexact  <= 1'b0;
            out_overflow <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data     <= rnd_data;
                out_inexact  <= rnd_inexact;
                out_overflow <= rnd_overflow;
            end
        end
    end

    // Inexact event counter: clear wins over increment, sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            inexact_cnt <= '0;
        end else if (stat_clr) begin
            inexact_cnt <= '0;
        end else if (out_fire && out_inexact && (inexact_cnt != {CNT_W{1'b1}})) begin
            inexact_cnt <= inexact_cnt + CNT_W'(1);
        end
    end

    // Overflow event counter: clear wins over increment, sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (stat_clr) begin
            ovf_cnt <= '0;
        end else if (out_fire && out_overflow && (ovf_cnt != {CNT_W{1'b1}})) begin
            ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end

endmodule
